counter: RTL and testbench

//   Timebase of the PWM generator; sits directly downstream of the register block.

---
 rtl/counter.sv | 113 +++++++++++
 tb/tb_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// PWM timebase: prescaled up/down counter wrapping at period, with tick and period_end pulses.
// Optional COUNTER_SHADOW_EN makes period/prescale take effect only at period boundaries.
module counter #(
    parameter int WIDTH     = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     period,
    input  logic                 en,
    input  logic                 count_reset,
    input  logic                 upnotdown,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]     count_val,
    output logic                 tick,
    output logic                 period_end
);

    logic [WIDTH-1:0]     count_r;
    logic [WIDTH-1:0]     count_nxt_s;
    logic [PRE_WIDTH-1:0] pre_cnt_r;
    logic [PRE_WIDTH-1:0] pre_cnt_nxt_s;
    logic                 tick_r;
    logic                 tick_nxt_s;
    logic                 period_end_r;
    logic                 period_end_nxt_s;
    logic                 wrap_s;
    logic [WIDTH-1:0]     period_use_s;
    logic [PRE_WIDTH-1:0] prescale_use_s;

`ifdef COUNTER_SHADOW_EN
    logic [WIDTH-1:0]     period_sh_r;
    logic [PRE_WIDTH-1:0] prescale_sh_r;

    // Shadow capture: on every clear cycle and on the wrapping step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh_r   <= {WIDTH{1'b0}};
            prescale_sh_r <= {PRE_WIDTH{1'b0}};
        end else if (count_reset || wrap_s) begin
            period_sh_r   <= period;
            prescale_sh_r <= prescale;
        end else begin
            period_sh_r   <= period_sh_r;
            prescale_sh_r <= prescale_sh_r;
        end
    end

    assign period_use_s   = period_sh_r;
    assign prescale_use_s = prescale_sh_r;
`else
    assign period_use_s   = period;
    assign prescale_use_s = prescale;
`endif

    // Next-state: clear > hold > prescaled step with wrap at period
    always_comb begin
        count_nxt_s      = count_r;
        pre_cnt_nxt_s    = pre_cnt_r;
        tick_nxt_s       = 1'b0;
        period_end_nxt_s = 1'b0;
        wrap_s           = 1'b0;
        if (count_reset) begin
            pre_cnt_nxt_s = {PRE_WIDTH{1'b0}};
            // Down-count reload uses the live period: the shadow is being captured on this edge
            count_nxt_s   = upnotdown ? {WIDTH{1'b0}} : period;
        end else if (!en) begin
            count_nxt_s   = count_r;
        end else if (pre_cnt_r >= prescale_use_s) begin
            pre_cnt_nxt_s = {PRE_WIDTH{1'b0}};
            tick_nxt_s    = 1'b1;
            if (upnotdown) begin
                if (count_r >= period_use_s) begin
                    count_nxt_s      = {WIDTH{1'b0}};
                    period_end_nxt_s = 1'b1;
                    wrap_s           = 1'b1;
                end else begin
                    count_nxt_s = count_r + WIDTH'(1);
                end
            end else begin
                if ((count_r == {WIDTH{1'b0}}) || (count_r > period_use_s)) begin
                    count_nxt_s      = period_use_s;
                    period_end_nxt_s = 1'b1;
                    wrap_s           = 1'b1;
                end else begin
                    count_nxt_s = count_r - WIDTH'(1);
                end
            end
        end else begin
            pre_cnt_nxt_s = pre_cnt_r + PRE_WIDTH'(1);
        end
    end

    // State and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r      <= {WIDTH{1'b0}};
            pre_cnt_r    <= {PRE_WIDTH{1'b0}};
            tick_r       <= 1'b0;
            period_end_r <= 1'b0;
        end else begin
            count_r      <= count_nxt_s;
            pre_cnt_r    <= pre_cnt_nxt_s;
            tick_r       <= tick_nxt_s;
            period_end_r <= period_end_nxt_s;
        end
    end

    assign count_val  = count_r;
    assign tick       = tick_r;
    assign period_end = period_end_r;

endmodule

// File: tb/tb_counter.sv
// Directed table-driven bench for counter (default build, live period/prescale).
module tb_counter;

    logic        clk;
    logic        rst_n;
    logic [15:0] period;
    logic        en;
    logic        count_reset;
    logic        upnotdown;
    logic [7:0]  prescale;
    logic [15:0] count_val;
    logic        tick;
    logic        period_end;

    int errors = 0;
    int checks = 0;

    counter #(.WIDTH(16), .PRE_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .period      (period),
        .en          (en),
        .count_reset (count_reset),
        .upnotdown   (upnotdown),
        .prescale    (prescale),
        .count_val   (count_val),
        .tick        (tick),
        .period_end  (period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        cr;
        logic        en;
        logic        up;
        logic [15:0] per;
        logic [7:0]  pre;
        logic [15:0] cnt;
        logic        tk;
        logic        pe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic cr, logic e, logic up, logic [15:0] per,
                                logic [7:0] pre, logic [15:0] cnt, logic tk, logic pe);
        vec_t v;
        v.name = n; v.cr = cr; v.en = e; v.up = up; v.per = per; v.pre = pre;
        v.cnt = cnt; v.tk = tk; v.pe = pe;
        return v;
    endfunction

    task automatic drive(input logic cr, input logic e, input logic up,
                         input logic [15:0] per, input logic [7:0] pre);
        count_reset = cr;
        en          = e;
        upnotdown   = up;
        period      = per;
        prescale    = pre;
    endtask

    task automatic check(input string n, input logic [15:0] cnt, input logic tk, input logic pe);
        checks++;
        if (count_val !== cnt || tick !== tk || period_end !== pe) begin
            errors++;
            $display("FAIL %s: got count=%0d tick=%b period_end=%b, expected count=%0d tick=%b period_end=%b",
                     n, count_val, tick, period_end, cnt, tk, pe);
        end
    endtask

    // One edge with given inputs, checked 1 time unit after the edge
    task automatic cyc(input string n, input logic cr, input logic e, input logic up,
                       input logic [15:0] per, input logic [7:0] pre,
                       input logic [15:0] cnt, input logic tk, input logic pe);
        drive(cr, e, up, per, pre);
        @(posedge clk);
        #1;
        check(n, cnt, tk, pe);
    endtask

    initial begin
        // Test 1: up, period 3, prescale 0
        vecs.push_back(mk("t1_clr",  1, 1, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk("t1_c1",   0, 1, 1, 3, 0, 1, 1, 0));
        vecs.push_back(mk("t1_c2",   0, 1, 1, 3, 0, 2, 1, 0));
        vecs.push_back(mk("t1_c3",   0, 1, 1, 3, 0, 3, 1, 0));
        vecs.push_back(mk("t1_wrap", 0, 1, 1, 3, 0, 0, 1, 1));
        vecs.push_back(mk("t1_c1b",  0, 1, 1, 3, 0, 1, 1, 0));
        // Test 2: period 2, prescale 2 -> step every 3rd cycle
        vecs.push_back(mk("t2_clr",  1, 1, 1, 2, 2, 0, 0, 0));
        vecs.push_back(mk("t2_p1",   0, 1, 1, 2, 2, 0, 0, 0));
        vecs.push_back(mk("t2_p2",   0, 1, 1, 2, 2, 0, 0, 0));
        vecs.push_back(mk("t2_s1",   0, 1, 1, 2, 2, 1, 1, 0));
        vecs.push_back(mk("t2_p3",   0, 1, 1, 2, 2, 1, 0, 0));
        vecs.push_back(mk("t2_p4",   0, 1, 1, 2, 2, 1, 0, 0));
        vecs.push_back(mk("t2_s2",   0, 1, 1, 2, 2, 2, 1, 0));
        vecs.push_back(mk("t2_p5",   0, 1, 1, 2, 2, 2, 0, 0));
        vecs.push_back(mk("t2_p6",   0, 1, 1, 2, 2, 2, 0, 0));
        vecs.push_back(mk("t2_wrap", 0, 1, 1, 2, 2, 0, 1, 1));
        // Test 3: down from reload, period 4
        vecs.push_back(mk("t3_clr",  1, 0, 0, 4, 0, 4, 0, 0));
        vecs.push_back(mk("t3_d3",   0, 1, 0, 4, 0, 3, 1, 0));
        vecs.push_back(mk("t3_d2",   0, 1, 0, 4, 0, 2, 1, 0));
        vecs.push_back(mk("t3_d1",   0, 1, 0, 4, 0, 1, 1, 0));
        vecs.push_back(mk("t3_d0",   0, 1, 0, 4, 0, 0, 1, 0));
        vecs.push_back(mk("t3_wrap", 0, 1, 0, 4, 0, 4, 1, 1));
        // period 0, both directions
        vecs.push_back(mk("p0_clr",  1, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("p0_up1",  0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk("p0_up2",  0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk("p0_dn",   0, 1, 0, 0, 0, 0, 1, 1));
        // prescale lowered below pre_cnt steps on the next edge
        vecs.push_back(mk("pl_clr",  1, 1, 1, 9, 5, 0, 0, 0));
        vecs.push_back(mk("pl_p1",   0, 1, 1, 9, 5, 0, 0, 0));
        vecs.push_back(mk("pl_p2",   0, 1, 1, 9, 5, 0, 0, 0));
        vecs.push_back(mk("pl_p3",   0, 1, 1, 9, 5, 0, 0, 0));
        vecs.push_back(mk("pl_low",  0, 1, 1, 9, 1, 1, 1, 0));
        // direction change continues from current value
        vecs.push_back(mk("dc_up2",  0, 1, 1, 9, 0, 2, 1, 0));
        vecs.push_back(mk("dc_up3",  0, 1, 1, 9, 0, 3, 1, 0));
        vecs.push_back(mk("dc_dn2",  0, 1, 0, 9, 0, 2, 1, 0));
        // down with count above a lowered period reloads to period
        vecs.push_back(mk("dp_up3",  0, 1, 1, 9, 0, 3, 1, 0));
        vecs.push_back(mk("dp_up4",  0, 1, 1, 9, 0, 4, 1, 0));
        vecs.push_back(mk("dp_up5",  0, 1, 1, 9, 0, 5, 1, 0));
        vecs.push_back(mk("dp_dn",   0, 1, 0, 3, 0, 3, 1, 1));

        rst_n = 1'b0;
        drive(0, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i])
            cyc(vecs[i].name, vecs[i].cr, vecs[i].en, vecs[i].up, vecs[i].per, vecs[i].pre,
                vecs[i].cnt, vecs[i].tk, vecs[i].pe);

        // Test 4: period lowered below count mid-run wraps on next step
        cyc("t4_clr", 1, 1, 1, 9, 0, 16'd0, 0, 0);
        for (int k = 1; k <= 5; k++)
            cyc("t4_run", 0, 1, 1, 9, 0, 16'(k), 1, 0);
        cyc("t4_wrap", 0, 1, 1, 3, 0, 16'd0, 1, 1);
        cyc("t4_after", 0, 1, 1, 3, 0, 16'd1, 1, 0);

        // Test 5: en low holds for 10 cycles then resumes
        cyc("t5_clr", 1, 1, 1, 9, 0, 16'd0, 0, 0);
        cyc("t5_c1", 0, 1, 1, 9, 0, 16'd1, 1, 0);
        cyc("t5_c2", 0, 1, 1, 9, 0, 16'd2, 1, 0);
        for (int k = 0; k < 10; k++)
            cyc("t5_hold", 0, 0, 1, 9, 0, 16'd2, 0, 0);
        cyc("t5_resume", 0, 1, 1, 9, 0, 16'd3, 1, 0);

        // Test 6: asynchronous reset mid-count, then clear with en high
        for (int k = 4; k <= 7; k++)
            cyc("t6_run", 0, 1, 1, 9, 0, 16'(k), 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_rst", 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc("t6_clr_held", 1, 1, 1, 9, 0, 16'd0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
